// File: rtl/mux16_rr_pkg.sv
// Shared types and constants for the 16-channel round-robin mux sampler.
package mux16_rr_pkg;

  localparam int NUM_CH = 16;

  typedef logic [3:0] ch_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: finds the first set request bit at or
// above (last+1) mod 16, wrapping 15->0. Rotate, priority-encode, un-rotate.
module rr_pick16
  import mux16_rr_pkg::*;
(
  input  logic [15:0] req,
  input  ch_idx_t     last,
  output ch_idx_t     win,
  output logic        any
);

  ch_idx_t     start;
  logic [31:0] dbl;
  logic [15:0] rot;
  ch_idx_t     off;

  // Rotate so the highest-priority channel lands at bit 0, pick the lowest set bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    start = last + 4'd1;
    dbl   = {req, req} >> start;
    rot   = dbl[15:0];
    off   = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) off = ch_idx_t'(i);
    end
    win = start + off;
    any = |req;
  end

endmodule

// File: rtl/mux16_rr_sampler.sv
// Round-robin scheduler driving one shared 16:1 bit mux: grants a channel,
// waits SETTLE_CYC edges, captures mux_y and offers it on a valid/ready port.
// Optional build macro MUX16_RR_GRANT_CNT_EN adds gnt_cnt and req_pending.
module mux16_rr_sampler
  import mux16_rr_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int CH_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     req,
  output logic [CH_W-1:0] sel,
  input  logic            mux_y,
  output logic [15:0]     grant,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [CH_W-1:0] out_ch,
  output logic            busy
`ifdef MUX16_RR_GRANT_CNT_EN
  ,
  output logic [15:0]     gnt_cnt,
  output logic [4:0]      req_pending
`endif
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t  state, state_nxt;
  ch_idx_t last_grant;
  ch_idx_t win;
  logic    any;
  logic    [3:0] cnt;
  logic    accept;

  rr_pick16 u_pick (
    .req  (req),
    .last (last_grant),
    .win  (win),
    .any  (any)
  );

  assign accept = (state == ST_HOLD) && out_valid && out_ready;
  assign busy   = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any)        state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0)  state_nxt = ST_HOLD;
      ST_HOLD:   if (accept)     state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Grant, settle counter, capture and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      grant      <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_ch     <= '0;
      last_grant <= ch_idx_t'(NUM_CH - 1);
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            sel   <= win;
            grant <= 16'd1 << win;
            cnt   <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_bit   <= mux_y;
            out_ch    <= sel;
            out_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          // sel is left unchanged so the mux keeps pointing at the last owner.
          if (accept) begin
            out_valid  <= 1'b0;
            grant      <= '0;
            last_grant <= sel;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MUX16_RR_GRANT_CNT_EN
  // Accepted-sample counter and registered request popcount.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt     <= '0;
      req_pending <= '0;
    end else begin
      if (accept) gnt_cnt <= gnt_cnt + 16'd1;
      req_pending <= 5'($countones(req));
    end
  end
`endif

endmodule
